// File: rtl/stfft_pkg.sv
// Shared types and helpers for the STFFT synthesis chain.
//   sample_t    : signed time-domain sample
//   ola_state_t : overlap-add frame state (IDLE / HEAD / TAIL)
//   sat_add     : saturating add, built only with OVERLAP_ADD_SAT_EN defined
package stfft_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        TAIL
    } ola_state_t;

`ifdef OVERLAP_ADD_SAT_EN
    // Adds two sign-extended operands and clamps the result to a w-bit signed
    // range. Wide enough for any sample width up to 32 bits; the caller casts
    // the result down to its own width.
    function automatic longint sat_add(input longint a, input longint b, input int w);
        longint sum;
        longint hi;
        longint lo;
        sum = a + b;
        hi  = (longint'(1) <<< (w - 1)) - 1;
        lo  = -hi - 1;
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction
`endif

endpackage

// File: rtl/ola_tail_buf.sv
// Tail buffer for overlap_add: holds the second half of the previous frame.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset (clears every entry)
//   wr_en_i, wr_addr_i, wr_data_i : synchronous write port
//   rd_addr_i, rd_data_o          : combinational read port
module ola_tail_buf #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en_i) mem_d[wr_addr_i] = wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) mem_q <= '0;
        else         mem_q <= mem_d;
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/overlap_add.sv
// 50%-overlap overlap-add for the STFFT synthesis path. The first HOP_SIZE
// samples of each frame are summed with the stored tail of the previous frame
// and emitted one cycle later; the last HOP_SIZE samples replace the tail.
// Build option: OVERLAP_ADD_SAT_EN -> saturate the sum, otherwise wrap.
// Ports:
//   clk_i, reset_i  : clock, synchronous active-high reset
//   frame_start_i   : qualifies the valid sample of this cycle as frame index 0
//   sample_valid_i  : input sample strobe (no backpressure)
//   sample_i        : signed IFFT sample
//   sample_o        : signed overlap-added sample, valid_o qualifies it
//   frame_done_o    : pulse after the last sample of a frame is accepted
//   frame_err_o     : pulse when a new frame starts before the current ended
module overlap_add
    import stfft_pkg::*;
#(
    parameter int FFT_SIZE = 256,
    parameter int HOP_SIZE = 128,
    parameter int DATA_W   = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     frame_start_i,
    input  logic                     sample_valid_i,
    input  logic signed [DATA_W-1:0] sample_i,
    output logic signed [DATA_W-1:0] sample_o,
    output logic                     valid_o,
    output logic                     frame_done_o,
    output logic                     frame_err_o
);

    localparam int IDX_W   = $clog2(FFT_SIZE);
    localparam int TAIL_AW = $clog2(HOP_SIZE);

    if (FFT_SIZE != 2 * HOP_SIZE) begin : g_bad_hop
        $error("overlap_add: FFT_SIZE must equal 2*HOP_SIZE");
    end
    if ((1 << TAIL_AW) != HOP_SIZE) begin : g_bad_pow2
        $error("overlap_add: HOP_SIZE must be a power of two");
    end

    ola_state_t              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [DATA_W-1:0] sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    start;
    ola_state_t              eff_state;
    logic [IDX_W-1:0]        eff_idx;
    logic                    tail_wr_en;
    logic signed [DATA_W-1:0] tail_rd;

    // A qualified frame_start always wins: the sample becomes index 0 of a
    // new frame regardless of the current state, so abort and restart are
    // handled in the same cycle without a bubble.
    always_comb begin
        start     = sample_valid_i & frame_start_i;
        eff_state = start ? HEAD : state_q;
        eff_idx   = start ? '0 : idx_q;

        state_d    = state_q;
        idx_d      = idx_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = start && (state_q != IDLE);
        tail_wr_en = 1'b0;

        if (sample_valid_i) begin
            case (eff_state)
                HEAD: begin
`ifdef OVERLAP_ADD_SAT_EN
                    sample_d = DATA_W'(sat_add(longint'(sample_i), longint'(tail_rd), DATA_W));
`else
                    // Low DATA_W bits of the sign-extended sum equal the
                    // plain DATA_W-bit two's-complement sum.
                    sample_d = sample_i + tail_rd;
`endif
                    valid_d = 1'b1;
                    idx_d   = eff_idx + 1'b1;
                    state_d = (eff_idx == IDX_W'(HOP_SIZE - 1)) ? TAIL : HEAD;
                end
                TAIL: begin
                    tail_wr_en = 1'b1;
                    if (eff_idx == IDX_W'(FFT_SIZE - 1)) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = eff_idx + 1'b1;
                    end
                end
                default: ;  // IDLE without start: sample dropped
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // HOP_SIZE is a power of two, so the low index bits address the tail
    // both as head index (read) and as index-HOP_SIZE (write).
    ola_tail_buf #(
        .DEPTH  (HOP_SIZE),
        .DATA_W (DATA_W),
        .AW     (TAIL_AW)
    ) u_tail (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_en_i   (tail_wr_en),
        .wr_addr_i (eff_idx[TAIL_AW-1:0]),
        .wr_data_i (sample_i),
        .rd_addr_i (eff_idx[TAIL_AW-1:0]),
        .rd_data_o (tail_rd)
    );

    assign sample_o     = sample_q;
    assign valid_o      = valid_q;
    assign frame_done_o = done_q;
    assign frame_err_o  = err_q;

endmodule

// File: tb/tb_overlap_add.sv
module tb_overlap_add;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        frame_start_i = 1'b0;
    logic        sample_valid_i = 1'b0;
    logic [15:0] sample_i = '0;
    logic [15:0] sample_o;
    logic        valid_o, frame_done_o, frame_err_o;

    overlap_add dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .frame_start_i  (frame_start_i),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .sample_o       (sample_o),
        .valid_o        (valid_o),
        .frame_done_o   (frame_done_o),
        .frame_err_o    (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int vcnt  = 0;
    int ecnt  = 0;
    int dcnt  = 0;

    logic [15:0] fin  [256];
    logic [15:0] fexp [128];

    typedef struct {
        logic        v;
        logic        fs;
        logic [15:0] d;
        logic        ev;
        logic [15:0] es;
        logic        ed;
        logic        ee;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle; outputs seen afterwards belong to this cycle's sample.
    task automatic step(input logic v, input logic fs, input logic [15:0] d);
        sample_valid_i = v;
        frame_start_i  = fs;
        sample_i       = d;
        @(posedge clk_i);
        #1;
        if (valid_o)      vcnt++;
        if (frame_err_o)  ecnt++;
        if (frame_done_o) dcnt++;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        reset_i = 1'b0;
    endtask

    // Plays fin[0..n-1] as one frame (start on sample 0) with gap idle cycles
    // after each sample, checking every output against fexp.
    task automatic play(input int n, input int gap, input bit err0);
        for (int i = 0; i < n; i++) begin
            step(1'b1, i == 0, fin[i]);
            if (i < 128) begin
                chk($sformatf("valid[%0d]", i), valid_o, 1);
                chk($sformatf("sample[%0d]", i), sample_o, fexp[i]);
            end else begin
                chk($sformatf("tail_valid[%0d]", i), valid_o, 0);
            end
            chk($sformatf("done[%0d]", i), frame_done_o, (i == 255));
            chk($sformatf("err[%0d]", i), frame_err_o, (err0 && i == 0));
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'b0, 16'h0);
                chk($sformatf("gap_valid[%0d]", i), valid_o, 0);
            end
        end
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'd11,   1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'd22,   1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 16'd33,   1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 16'd100,  1'b1, 16'd100,  1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 16'd0,    1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'hFFFB, 1'b1, 16'hFFFB, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 16'd42,   1'b1, 16'd42,   1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 16'd0,    1'b0, 16'h0000, 1'b0, 1'b0};

        // Reset state
        do_reset();
        chk("rst_sample", sample_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_done", frame_done_o, 0);
        chk("rst_err", frame_err_o, 0);

        // Table: drops in IDLE, start, gap hold, abort inside HEAD (tail still 0)
        for (int k = 0; k < 10; k++) begin
            step(tbl[k].v, tbl[k].fs, tbl[k].d);
            chk($sformatf("tbl_valid[%0d]", k), valid_o, tbl[k].ev);
            if (tbl[k].ev) chk($sformatf("tbl_sample[%0d]", k), sample_o, tbl[k].es);
            chk($sformatf("tbl_done[%0d]", k), frame_done_o, tbl[k].ed);
            chk($sformatf("tbl_err[%0d]", k), frame_err_o, tbl[k].ee);
        end

        // One frame of 100s after reset: 128 outputs of 100, done on 255
        do_reset();
        vcnt = 0; dcnt = 0;
        for (int i = 0; i < 256; i++) fin[i] = 16'd100;
        for (int i = 0; i < 128; i++) fexp[i] = 16'd100;
        play(256, 0, 1'b0);
        chk("f100_valid_count", vcnt, 128);
        chk("f100_done_count", dcnt, 1);

        // Ramp A (overlaps the 100s tail) then B of 1s back-to-back
        for (int i = 0; i < 256; i++) fin[i] = 16'(i);
        for (int i = 0; i < 128; i++) fexp[i] = 16'(i + 100);
        play(256, 0, 1'b0);
        for (int i = 0; i < 256; i++) fin[i] = 16'd1;
        for (int i = 0; i < 128; i++) fexp[i] = 16'(129 + i);
        play(256, 0, 1'b0);

        // Two frames of 0x7000: second frame overflows
        do_reset();
        for (int i = 0; i < 256; i++) fin[i] = 16'h7000;
        for (int i = 0; i < 128; i++) fexp[i] = 16'h7000;
        play(256, 0, 1'b0);
`ifdef OVERLAP_ADD_SAT_EN
        for (int i = 0; i < 128; i++) fexp[i] = 16'h7FFF;
`else
        for (int i = 0; i < 128; i++) fexp[i] = 16'hE000;
`endif
        play(256, 0, 1'b0);

        // 10 dropped samples in IDLE, then a frame with 3-cycle gaps
        do_reset();
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 16'(1000 + i));
            chk($sformatf("drop_valid[%0d]", i), valid_o, 0);
        end
        chk("drop_count", vcnt, 0);
        for (int i = 0; i < 256; i++) fin[i] = 16'(i * 7 - 300);
        for (int i = 0; i < 128; i++) fexp[i] = 16'(i * 7 - 300);
        play(256, 3, 1'b0);

        // Abort: previous tail of 3s, frame of 5s cut at index 200, then 1s
        do_reset();
        for (int i = 0; i < 256; i++) fin[i] = 16'd3;
        for (int i = 0; i < 128; i++) fexp[i] = 16'd3;
        play(256, 0, 1'b0);
        ecnt = 0;
        for (int i = 0; i < 256; i++) fin[i] = 16'd5;
        for (int i = 0; i < 128; i++) fexp[i] = 16'd8;
        play(200, 0, 1'b0);
        for (int i = 0; i < 256; i++) fin[i] = 16'd1;
        for (int i = 0; i < 128; i++) fexp[i] = (i < 72) ? 16'd6 : 16'd4;
        play(256, 0, 1'b1);
        chk("abort_err_count", ecnt, 1);

        // Reset mid-HEAD cancels output and clears the tail (which holds 1s)
        for (int i = 0; i < 256; i++) fin[i] = 16'd2;
        for (int i = 0; i < 128; i++) fexp[i] = 16'd3;
        play(10, 0, 1'b0);
        reset_i = 1'b1;
        step(1'b1, 1'b0, 16'd9);
        reset_i = 1'b0;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_sample", sample_o, 0);
        for (int i = 0; i < 256; i++) fin[i] = 16'd7;
        for (int i = 0; i < 128; i++) fexp[i] = 16'd7;
        play(256, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
